// File: rtl/prog_sequencer.sv
// Program sequencer for the 9-bit accumulator processor: PC, fetch/exec/load-wait/halt FSM
// and commit strobe. Optional busy-cycle counter enabled by defining SEQ_CYCLE_COUNT_EN.
module prog_sequencer #(
    parameter int unsigned     PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int unsigned     CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             Branch,
    input  logic             BranchTaken,
    input  logic             MemToReg,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Fetch,
    output logic             CommitEn,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StMemWait,
        StHalt
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StIdle;
            pc_q    <= START_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        Fetch    = 1'b0;
        CommitEn = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    pc_d    = START_ADDR;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                Fetch   = 1'b1;
                Busy    = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                Busy = 1'b1;
                // Halt outranks load, which outranks the normal commit path.
                if (Ack) begin
                    state_d = StHalt;
                end else if (MemToReg) begin
                    state_d = StMemWait;
                end else begin
                    CommitEn = 1'b1;
                    pc_d     = (Branch && BranchTaken) ? Target : pc_q + PC_W'(1);
                    state_d  = StFetch;
                end
            end
            StMemWait: begin
                Busy     = 1'b1;
                CommitEn = 1'b1;
                pc_d     = pc_q + PC_W'(1);
                state_d  = StFetch;
            end
            StHalt: begin
                Done = 1'b1;
                if (!Start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ProgCtr = pc_q;

`ifdef SEQ_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle && Start) begin
            cnt_d = '0;
        end else if (Busy && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CycleCnt = cnt_q;
`else
    assign CycleCnt = '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer; a small instruction ROM model feeds the decoder inputs
// from ProgCtr so the sequencer runs real little programs.
module tb_prog_sequencer;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DEPTH = 1 << PC_W;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic             Ack;
    logic             Branch;
    logic             BranchTaken;
    logic             MemToReg;
    logic [PC_W-1:0]  Target;
    logic [PC_W-1:0]  ProgCtr;
    logic             Fetch;
    logic             CommitEn;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] CycleCnt;

    logic            rom_ack    [DEPTH];
    logic            rom_branch [DEPTH];
    logic            rom_taken  [DEPTH];
    logic            rom_load   [DEPTH];
    logic [PC_W-1:0] rom_tgt    [DEPTH];

    int checks = 0;
    int errors = 0;

    prog_sequencer #(
        .PC_W      (PC_W),
        .START_ADDR('0),
        .CNT_W     (CNT_W)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Ack        (Ack),
        .Branch     (Branch),
        .BranchTaken(BranchTaken),
        .MemToReg   (MemToReg),
        .Target     (Target),
        .ProgCtr    (ProgCtr),
        .Fetch      (Fetch),
        .CommitEn   (CommitEn),
        .Busy       (Busy),
        .Done       (Done),
        .CycleCnt   (CycleCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Decoder model: the instruction at ProgCtr drives the decoded control inputs.
    assign Ack         = rom_ack[ProgCtr];
    assign Branch      = rom_branch[ProgCtr];
    assign BranchTaken = rom_taken[ProgCtr];
    assign MemToReg    = rom_load[ProgCtr];
    assign Target      = rom_tgt[ProgCtr];

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef SEQ_CYCLE_COUNT_EN
        return CNT_W'(n);
`else
        return '0;
`endif
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) begin
            rom_ack[i]    = 1'b0;
            rom_branch[i] = 1'b0;
            rom_taken[i]  = 1'b0;
            rom_load[i]   = 1'b0;
            rom_tgt[i]    = '0;
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    // Pulse Start from IDLE; returns in the FETCH cycle following acceptance.
    task automatic start_prog();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Start = 1'b0;
        step();
        step();
        Reset = 1'b1;
        checks++;
        if (ProgCtr !== 10'h000 || Fetch !== 1'b0 || CommitEn !== 1'b0 || Busy !== 1'b0 ||
            Done !== 1'b0 || CycleCnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: pc=%h fetch=%b commit=%b busy=%b done=%b cnt=%0d, need 000 0 0 0 0 0",
                     ProgCtr, Fetch, CommitEn, Busy, Done, CycleCnt);
        end
        step();
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: busy=%b, need 0", Busy);
        end
    endtask

    task automatic test_alu_program();
        int commits = 0;
        int fetches = 0;
        clear_rom();
        rom_ack[3] = 1'b1;
        start_prog();
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) begin
                checks++;
                if (Fetch !== (k % 2 == 1) || Busy !== 1'b1 || Done !== 1'b0) begin
                    errors++;
                    $display("FAIL alu_cycle%0d: fetch=%b busy=%b done=%b, need %b 1 0",
                             k, Fetch, Busy, Done, (k % 2 == 1));
                end
            end
            if (Fetch === 1'b1) begin
                checks++;
                if (ProgCtr !== PC_W'(fetches)) begin
                    errors++;
                    $display("FAIL alu_fetch_pc: pc=%h, need %h", ProgCtr, fetches);
                end
                fetches++;
            end
            if (CommitEn === 1'b1) commits++;
            if (k < 9) step();
        end
        checks++;
        if (Done !== 1'b1 || fetches != 4 || commits != 3) begin
            errors++;
            $display("FAIL alu_done: done=%b fetches=%0d commits=%0d, need 1 4 3",
                     Done, fetches, commits);
        end
        checks++;
        if (CycleCnt !== exp_cnt(8) || ProgCtr !== 10'h003) begin
            errors++;
            $display("FAIL alu_halt_cnt: cnt=%0d pc=%h, need %0d 003", CycleCnt, ProgCtr, exp_cnt(8));
        end
        step();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL alu_to_idle: done=%b busy=%b, need 0 0", Done, Busy);
        end
    endtask

    task automatic test_load();
        clear_rom();
        rom_load[0] = 1'b1;
        rom_ack[1]  = 1'b1;
        start_prog();
        step();
        checks++;
        if (CommitEn !== 1'b0 || Busy !== 1'b1 || Fetch !== 1'b0) begin
            errors++;
            $display("FAIL load_exec: commit=%b busy=%b fetch=%b, need 0 1 0", CommitEn, Busy, Fetch);
        end
        step();
        checks++;
        if (CommitEn !== 1'b1 || Fetch !== 1'b0 || ProgCtr !== 10'h000) begin
            errors++;
            $display("FAIL load_memwait: commit=%b fetch=%b pc=%h, need 1 0 000",
                     CommitEn, Fetch, ProgCtr);
        end
        step();
        checks++;
        if (Fetch !== 1'b1 || ProgCtr !== 10'h001) begin
            errors++;
            $display("FAIL load_next_fetch: fetch=%b pc=%h, need 1 001", Fetch, ProgCtr);
        end
        step();
        step();
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL load_halt: done=%b, need 1", Done);
        end
        step();
    endtask

    task automatic run_branch(input logic taken, input logic [PC_W-1:0] next_pc);
        bit seen = 1'b0;
        clear_rom();
        rom_branch[5] = 1'b1;
        rom_taken[5]  = taken;
        rom_tgt[5]    = 10'h02A;
        rom_ack[6]    = 1'b1;
        rom_ack[10'h02A] = 1'b1;
        start_prog();
        for (int i = 0; i < 40 && !seen; i++) begin
            if (Fetch === 1'b1 && ProgCtr === 10'h005) seen = 1'b1;
            else step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL branch_reach_pc5: timeout, pc=%h", ProgCtr);
        end else begin
            step();
            step();
            checks++;
            if (Fetch !== 1'b1 || ProgCtr !== next_pc) begin
                errors++;
                $display("FAIL branch_taken%b: fetch=%b pc=%h, need 1 %h", taken, Fetch, ProgCtr, next_pc);
            end
        end
        step();
        step();
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL branch_halt: done=%b, need 1", Done);
        end
        step();
    endtask

    task automatic test_branch();
        run_branch(1'b1, 10'h02A);
        run_branch(1'b0, 10'h006);
    endtask

    task automatic test_wrap_ack_branch();
        clear_rom();
        rom_branch[0] = 1'b1;
        rom_taken[0]  = 1'b1;
        rom_tgt[0]    = 10'h3FF;
        start_prog();
        step();
        step();
        checks++;
        if (Fetch !== 1'b1 || ProgCtr !== 10'h3FF) begin
            errors++;
            $display("FAIL wrap_reach_3ff: fetch=%b pc=%h, need 1 3ff", Fetch, ProgCtr);
        end
        // Turn address 0 into halt+branch before the wrap lands there.
        rom_ack[0] = 1'b1;
        rom_tgt[0] = 10'h155;
        step();
        checks++;
        if (CommitEn !== 1'b1) begin
            errors++;
            $display("FAIL wrap_exec_commit: commit=%b, need 1", CommitEn);
        end
        step();
        checks++;
        if (Fetch !== 1'b1 || ProgCtr !== 10'h000) begin
            errors++;
            $display("FAIL wrap_to_zero: fetch=%b pc=%h, need 1 000", Fetch, ProgCtr);
        end
        step();
        checks++;
        if (CommitEn !== 1'b0) begin
            errors++;
            $display("FAIL ackbranch_commit: commit=%b, need 0", CommitEn);
        end
        step();
        checks++;
        if (Done !== 1'b1 || ProgCtr !== 10'h000) begin
            errors++;
            $display("FAIL ackbranch_halt: done=%b pc=%h, need 1 000", Done, ProgCtr);
        end
        step();
    endtask

    task automatic test_reset_memwait();
        clear_rom();
        rom_load[0] = 1'b1;
        start_prog();
        step();
        step();
        checks++;
        if (CommitEn !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_memwait: commit=%b, need 1", CommitEn);
        end
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        checks++;
        if (Busy !== 1'b0 || ProgCtr !== 10'h000 || CommitEn !== 1'b0 || CycleCnt !== 16'h0 ||
            Done !== 1'b0 || Fetch !== 1'b0) begin
            errors++;
            $display("FAIL rst_memwait: busy=%b pc=%h commit=%b cnt=%0d done=%b fetch=%b, need 0 000 0 0 0 0",
                     Busy, ProgCtr, CommitEn, CycleCnt, Done, Fetch);
        end
        step();
    endtask

    task automatic test_start_hold();
        clear_rom();
        rom_ack[2] = 1'b1;
        start_prog();
        step();
        Start = 1'b1;
        step();
        Start = 1'b0;
        checks++;
        if (Fetch !== 1'b1 || ProgCtr !== 10'h001 || CycleCnt !== exp_cnt(2)) begin
            errors++;
            $display("FAIL busy_start_ignored: fetch=%b pc=%h cnt=%0d, need 1 001 %0d",
                     Fetch, ProgCtr, CycleCnt, exp_cnt(2));
        end
        step();
        step();
        step();
        Start = 1'b1;
        step();
        checks++;
        if (Done !== 1'b1 || ProgCtr !== 10'h002 || CycleCnt !== exp_cnt(6)) begin
            errors++;
            $display("FAIL hold_halt: done=%b pc=%h cnt=%0d, need 1 002 %0d",
                     Done, ProgCtr, CycleCnt, exp_cnt(6));
        end
        step();
        step();
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || CycleCnt !== exp_cnt(6)) begin
            errors++;
            $display("FAIL hold_stays: done=%b busy=%b cnt=%0d, need 1 0 %0d",
                     Done, Busy, CycleCnt, exp_cnt(6));
        end
        Start = 1'b0;
        step();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || CycleCnt !== exp_cnt(6)) begin
            errors++;
            $display("FAIL hold_release: done=%b busy=%b cnt=%0d, need 0 0 %0d",
                     Done, Busy, CycleCnt, exp_cnt(6));
        end
        step();
        checks++;
        if (Busy !== 1'b0 || Fetch !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_halt: busy=%b fetch=%b, need 0 0", Busy, Fetch);
        end
    endtask

    initial begin
        clear_rom();
        Reset = 1'b0;
        Start = 1'b0;
        test_reset();
        test_alu_program();
        test_load();
        test_branch();
        test_wrap_ack_branch();
        test_reset_memwait();
        test_start_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Multi-cycle program sequencer for the 9-bit accumulator processor. Owns the program counter, runs a fetch/execute/load-wait/halt state machine, and gates register-file and data-memory writes through a single commit strobe. Sits between the Start/Done handshake at the top level and the instruction decoder, consuming its Branch, MemToReg and Ack outputs.

## Interface

- PC_W, 10, program counter width; instruction ROM depth 2^PC_W
- START_ADDR, 0, PC value loaded on reset and on each accepted Start
- CNT_W, 16, cycle counter width

- Clk  in  1  sole clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- Start  in  1  level request to run program; sampled only in IDLE
- Ack  in  1  decoded halt instruction (all-ones); valid in EXEC
- Branch  in  1  decoded branch instruction; valid in EXEC
- BranchTaken  in  1  branch condition (1 for unconditional B, flag for BTRU); valid in EXEC
- MemToReg  in  1  decoded load; valid in EXEC
- Target  in  PC_W  branch target address; valid in EXEC
- ProgCtr  out  PC_W  current instruction address
- Fetch  out  1  instruction register load enable
- CommitEn  out  1  global write enable; ANDed with WriteR0/GenRegWrite/WriteMem downstream
- Busy  out  1  program running (FETCH, EXEC, MEMWAIT)
- Done  out  1  program halted, result valid
- CycleCnt  out  CNT_W  cycles spent running the last/current program

## Operation

- States: IDLE, FETCH, EXEC, MEMWAIT, HALT. All outputs are decoded from state (Moore), except CommitEn in EXEC, which depends on MemToReg/Ack.
- IDLE: Start=1 -> ProgCtr<=START_ADDR, CycleCnt<=0, go FETCH. Start=0 -> stay.
- FETCH: Fetch=1 for exactly one cycle -> EXEC.
- EXEC, priority order:
  - Ack=1 -> HALT; CommitEn=0; ProgCtr unchanged. Ack overrides Branch/MemToReg.
  - MemToReg=1 -> MEMWAIT; CommitEn=0; ProgCtr unchanged.
  - else CommitEn=1; ProgCtr<=Target if Branch&&BranchTaken, else ProgCtr+1; -> FETCH.
- MEMWAIT: CommitEn=1; ProgCtr<=ProgCtr+1 (loads never branch) -> FETCH.
- HALT: Done=1. Stay while Start=1; Start=0 -> IDLE.
- ProgCtr+1 is modulo 2^PC_W: the all-ones address wraps to 0. Target is used unmodified.
- Start while Busy is ignored. Start held high into HALT does not restart the program; Start must drop, then rise again in IDLE.
- Busy=1 exactly in FETCH/EXEC/MEMWAIT. Done=1 exactly in HALT.

## Timing

- Reset=0 at an edge -> next cycle: state IDLE, ProgCtr=START_ADDR, Fetch=0, CommitEn=0, Busy=0, Done=0, CycleCnt=0. This applies from any state. A commit pending in EXEC/MEMWAIT is dropped.
- Start accepted at edge N -> FETCH in cycle N+1.
- Non-load instruction: 2 cycles (FETCH, EXEC). Load: 3 cycles (FETCH, EXEC, MEMWAIT). Halt instruction: 2 cycles, then Done.
- CommitEn is high for one cycle per committed instruction: in EXEC for non-loads, in MEMWAIT for loads.
- Done rises in the cycle after the EXEC in which Ack=1 was seen. Done falls in the cycle after Start is seen low in HALT.

## Configuration

- SEQ_CYCLE_COUNT_EN defined: CycleCnt increments by 1 every cycle Busy=1. It saturates at 2^CNT_W-1, clears on Start acceptance and on reset, and holds its value in HALT and IDLE.
- SEQ_CYCLE_COUNT_EN undefined: no counter register is built and CycleCnt is constant 0.

## Test plan

- Reset, then pulse Start; ROM holds 3 ALU ops then halt at PC 3 -> Fetch at PC 0,1,2,3; 3 CommitEn pulses; Done=1 nine cycles after acceptance; CycleCnt=8 (with macro).
- Load at PC 0 -> EXEC shows CommitEn=0, MEMWAIT shows CommitEn=1; ProgCtr=1 at the next FETCH, 3 cycles after the first FETCH.
- Branch=1 at PC 5 with Target=0x2A: BranchTaken=1 -> next FETCH at 0x2A; BranchTaken=0 -> next FETCH at 6.
- PC 0x3FF holds a non-branch ALU op (PC_W=10) -> next FETCH at 0x000. Ack and Branch asserted together in EXEC -> HALT, ProgCtr unchanged, no commit.
- Reset=0 during MEMWAIT -> next cycle IDLE, ProgCtr=0, CommitEn=0, Busy=0, CycleCnt=0.
- Start held high through HALT -> Done stays 1. Start low -> IDLE, Done=0. Start pulse while Busy -> no effect on ProgCtr or CycleCnt.
